// File: rtl/writeback_queue_pkg.sv
// -----------------------------------------------------------------------------
// writeback_queue_pkg
//   Shared register-file geometry for the writeback queue and its lookup
//   sub-module. The same values are used by the register file itself:
//   32 registers of 32 bits, addressed by 5 bits, with R0 hard-wired to zero.
// -----------------------------------------------------------------------------
package writeback_queue_pkg;

  localparam int RF_ADDR_W = 5;
  localparam int RF_DATA_W = 32;

endpackage

// File: rtl/wbq_fwd_match.sv
// -----------------------------------------------------------------------------
// wbq_fwd_match
//   One bypass lookup port. Compares a read address against a set of pending
//   writes and returns the data of the youngest valid match.
//   Entries are supplied age-ordered: index 0 is the oldest candidate and
//   index N-1 the youngest, so a later match overrides an earlier one.
//   Address 0 (R0) never hits because R0 always reads as zero.
// Ports:
//   lk_addr    in   ADDR_W     register address being read
//   ent_addr   in   N*ADDR_W   candidate destination addresses, oldest first
//   ent_data   in   N*DATA_W   candidate write values, oldest first
//   ent_valid  in   N          candidate valid flags
//   hit        out  1          a valid candidate targets lk_addr
//   data       out  DATA_W     youngest matching value, 0 when no hit
// -----------------------------------------------------------------------------
module wbq_fwd_match
  import writeback_queue_pkg::*;
#(
  parameter int N      = 5,
  parameter int ADDR_W = RF_ADDR_W,
  parameter int DATA_W = RF_DATA_W
) (
  input  logic [ADDR_W-1:0]   lk_addr,
  input  logic [N*ADDR_W-1:0] ent_addr,
  input  logic [N*DATA_W-1:0] ent_data,
  input  logic [N-1:0]        ent_valid,
  output logic                hit,
  output logic [DATA_W-1:0]   data
);

  logic lk_nonzero;

  assign lk_nonzero = (lk_addr != {ADDR_W{1'b0}});

  // Priority select: scanning oldest to youngest lets the youngest match win.
  always_comb begin
    hit  = 1'b0;
    data = {DATA_W{1'b0}};
    for (int i = 0; i < N; i++) begin
      hit  = hit | (ent_valid[i] & lk_nonzero & (ent_addr[i*ADDR_W +: ADDR_W] == lk_addr));
      data = (ent_valid[i] & lk_nonzero & (ent_addr[i*ADDR_W +: ADDR_W] == lk_addr))
             ? ent_data[i*DATA_W +: DATA_W] : data;
    end
  end

endmodule

// File: rtl/writeback_queue.sv
// -----------------------------------------------------------------------------
// writeback_queue
//   Small FIFO between the execute/load path and the register-file write port.
//   Accepts one write per cycle, drains one per cycle into a registered
//   (enable, RW, PW) stage, and stalls the drain while rf_hold is high.
//   Writes to R0 complete the handshake but are dropped.
//   Optional bypass lookups on the A/B/D read ports see every queued entry plus
//   the output stage, youngest first.
// Configuration macro:
//   WBQ_FORWARD_EN  defined   -> three wbq_fwd_match lookup ports are built
//                   undefined -> lk_hit and lk_data are constant zero
// Ports:
//   clock      in   1          rising-edge clock (register-file clock)
//   reset_n    in   1          asynchronous active-low reset
//   in_valid   in   1          producer offers a write
//   in_ready   out  1          a slot is free (count != DEPTH)
//   in_addr    in   ADDR_W     destination register
//   in_data    in   DATA_W     write value
//   rf_hold    in   1          write port borrowed this cycle, do not pop
//   rf_enable  out  1          register-file write enable (registered)
//   rf_addr    out  ADDR_W     register-file RW (registered)
//   rf_data    out  DATA_W     register-file PW (registered)
//   lk_addr    in   3*ADDR_W   lookup addresses {D,B,A}
//   lk_hit     out  3          pending-write hit {D,B,A}
//   lk_data    out  3*DATA_W   forwarded values {D,B,A}
// -----------------------------------------------------------------------------
module writeback_queue
  import writeback_queue_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ADDR_W-1:0]   in_addr,
  input  logic [DATA_W-1:0]   in_data,
  input  logic                rf_hold,
  output logic                rf_enable,
  output logic [ADDR_W-1:0]   rf_addr,
  output logic [DATA_W-1:0]   rf_data,
  input  logic [3*ADDR_W-1:0] lk_addr,
  output logic [2:0]          lk_hit,
  output logic [3*DATA_W-1:0] lk_data
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  logic [ADDR_W-1:0] mem_addr [DEPTH];
  logic [DATA_W-1:0] mem_data [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              do_push;
  logic              do_pop;

  // Full is judged on the registered count only, so a pop in the same cycle
  // never opens a slot early and in_ready has no path from rf_hold.
  assign in_ready = (count != FULL_COUNT);
  assign do_push  = in_valid & in_ready & (in_addr != {ADDR_W{1'b0}});
  assign do_pop   = (count != {CNT_W{1'b0}}) & ~rf_hold;

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= {PTR_W{1'b0}};
      rd_ptr <= {PTR_W{1'b0}};
      count  <= {CNT_W{1'b0}};
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage, written at the tail.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_addr[i] <= {ADDR_W{1'b0}};
        mem_data[i] <= {DATA_W{1'b0}};
      end
    end else begin
      if (do_push) begin
        mem_addr[wr_ptr] <= in_addr;
        mem_data[wr_ptr] <= in_data;
      end
    end
  end

  // Registered write-port stage; address/data hold when idle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rf_enable <= 1'b0;
      rf_addr   <= {ADDR_W{1'b0}};
      rf_data   <= {DATA_W{1'b0}};
    end else begin
      if (do_pop) begin
        rf_enable <= 1'b1;
        rf_addr   <= mem_addr[rd_ptr];
        rf_data   <= mem_data[rd_ptr];
      end else begin
        rf_enable <= 1'b0;
      end
    end
  end

`ifdef WBQ_FORWARD_EN
  localparam int NENT = DEPTH + 1;

  logic [NENT*ADDR_W-1:0] ent_addr;
  logic [NENT*DATA_W-1:0] ent_data;
  logic [NENT-1:0]        ent_valid;

  // Age-ordered candidate list: slot 0 is the output stage (oldest), slot k+1
  // is the k-th queued entry counted from the head.
  always_comb begin
    ent_addr  = {(NENT*ADDR_W){1'b0}};
    ent_data  = {(NENT*DATA_W){1'b0}};
    ent_valid = {NENT{1'b0}};
    ent_addr[0 +: ADDR_W] = rf_addr;
    ent_data[0 +: DATA_W] = rf_data;
    ent_valid[0]          = rf_enable;
    for (int k = 0; k < DEPTH; k++) begin
      ent_addr[(k+1)*ADDR_W +: ADDR_W] = mem_addr[PTR_W'(rd_ptr + PTR_W'(k))];
      ent_data[(k+1)*DATA_W +: DATA_W] = mem_data[PTR_W'(rd_ptr + PTR_W'(k))];
      ent_valid[k+1]                   = (CNT_W'(k) < count);
    end
  end

  for (genvar p = 0; p < 3; p++) begin : g_lookup
    wbq_fwd_match #(
      .N      (NENT),
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
    ) u_match (
      .lk_addr   (lk_addr[p*ADDR_W +: ADDR_W]),
      .ent_addr  (ent_addr),
      .ent_data  (ent_data),
      .ent_valid (ent_valid),
      .hit       (lk_hit[p]),
      .data      (lk_data[p*DATA_W +: DATA_W])
    );
  end
`else
  // No bypass: consumers must stall on pending writes.
  logic lk_addr_unused;

  assign lk_addr_unused = ^lk_addr;
  assign lk_hit         = 3'b000;
  assign lk_data        = {(3*DATA_W){1'b0}};
`endif

endmodule

// File: tb/tb_writeback_queue.sv
// -----------------------------------------------------------------------------
// tb_writeback_queue
//   Directed bench for writeback_queue (DEPTH=4, 32x32 register file).
//   A behavioural register file and a log of emitted writes are kept from the
//   write-port outputs; expected values are written out by hand per test.
// -----------------------------------------------------------------------------
module tb_writeback_queue;

  logic        clock;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_addr;
  logic [31:0] in_data;
  logic        rf_hold;
  logic        rf_enable;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;
  logic [14:0] lk_addr;
  logic [2:0]  lk_hit;
  logic [95:0] lk_data;

  int total;
  int bad;

  logic [31:0] rf_model [32];
  logic [36:0] wr_log [$];

  writeback_queue dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_addr   (in_addr),
    .in_data   (in_data),
    .rf_hold   (rf_hold),
    .rf_enable (rf_enable),
    .rf_addr   (rf_addr),
    .rf_data   (rf_data),
    .lk_addr   (lk_addr),
    .lk_hit    (lk_hit),
    .lk_data   (lk_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Register file model and write log, committed at the edge that ends an enable cycle.
  always @(posedge clock) begin
    if (reset_n && rf_enable) begin
      rf_model[rf_addr] <= rf_data;
      wr_log.push_back({rf_addr, rf_data});
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_lookup(input string tag, input logic [2:0] hit_fwd,
                               input logic [95:0] data_fwd);
`ifdef WBQ_FORWARD_EN
    check({tag, "_hit"}, 64'(lk_hit), 64'(hit_fwd));
    check({tag, "_dB"}, 64'(lk_data[63:32]), 64'(data_fwd[63:32]));
    check({tag, "_dA"}, 64'(lk_data[31:0]), 64'(data_fwd[31:0]));
    check({tag, "_dD"}, 64'(lk_data[95:64]), 64'(data_fwd[95:64]));
`else
    check({tag, "_hit"}, 64'(lk_hit), 64'd0);
    check({tag, "_data"}, 64'(lk_data[95:32]) | 64'(lk_data[31:0]), 64'd0);
`endif
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_addr  = 5'd0;
    in_data  = 32'd0;
    rf_hold  = 1'b0;
    lk_addr  = 15'd0;
    for (int i = 0; i < 32; i++) rf_model[i] = 32'd0;

    // Reset state
    #12;
    check("rst_en", 64'(rf_enable), 64'd0);
    check("rst_addr", 64'(rf_addr), 64'd0);
    check("rst_data", 64'(rf_data), 64'd0);
    check("rst_ready", 64'(in_ready), 64'd1);
    #2 reset_n = 1'b1;
    step();

    // 1 Single write: commit two edges after the push edge
    in_valid = 1'b1; in_addr = 5'd3; in_data = 32'h14;
    step();
    in_valid = 1'b0;
    check("t1_en_n", 64'(rf_enable), 64'd0);
    lk_addr = {5'd0, 5'd0, 5'd3};
    expect_lookup("t1_lkq", 3'b001, {64'd0, 32'h14});
    step();
    check("t1_en", 64'(rf_enable), 64'd1);
    check("t1_addr", 64'(rf_addr), 64'd3);
    check("t1_data", 64'(rf_data), 64'h14);
    expect_lookup("t1_lko", 3'b001, {64'd0, 32'h14});
    step();
    check("t1_en_off", 64'(rf_enable), 64'd0);
    check("t1_rf3", 64'(rf_model[3]), 64'h14);
    check("t1_cnt", 64'(wr_log.size()), 64'd1);
    lk_addr = 15'd0;

    // 2 Fill/full under hold, then drain in order
    wr_log.delete();
    rf_hold = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1; in_addr = 5'(i); in_data = 32'h100 + 32'(i);
      step();
    end
    check("t2_full", 64'(in_ready), 64'd0);
    in_addr = 5'd5; in_data = 32'h105;
    step();
    check("t2_full2", 64'(in_ready), 64'd0);
    check("t2_hold_en", 64'(rf_enable), 64'd0);
    in_valid = 1'b0;
    rf_hold  = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      step();
      check("t2_en", 64'(rf_enable), 64'd1);
      check("t2_addr", 64'(rf_addr), 64'(i));
      check("t2_data", 64'(rf_data), 64'h100 + 64'(i));
    end
    step();
    check("t2_done", 64'(rf_enable), 64'd0);
    check("t2_cnt", 64'(wr_log.size()), 64'd4);
    check("t2_ready", 64'(in_ready), 64'd1);

    // 3 Streaming 31 writes at full rate
    wr_log.delete();
    for (int i = 1; i <= 31; i++) begin
      in_valid = 1'b1; in_addr = 5'(i); in_data = 32'h14 + 32'(i);
      check("t3_ready", 64'(in_ready), 64'd1);
      step();
    end
    in_valid = 1'b0;
    step(); step(); step();
    check("t3_cnt", 64'(wr_log.size()), 64'd31);
    for (int i = 1; i <= 31; i++) begin
      if (wr_log.size() >= i)
        check("t3_order", 64'(wr_log[i-1]), 64'({5'(i), 32'h14 + 32'(i)}));
      check("t3_rd_ra", 64'(rf_model[i]), 64'h14 + 64'(i));
    end

    // 4 R0 discard
    wr_log.delete();
    in_valid = 1'b1; in_addr = 5'd0; in_data = 32'hFFFF_FFFF;
    check("t4_ready", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    lk_addr = 15'd0;
    check("t4_lkA", 64'(lk_hit[0]), 64'd0);
    step(); step();
    check("t4_nowr", 64'(wr_log.size()), 64'd0);
    check("t4_ready2", 64'(in_ready), 64'd1);

    // 5 Forwarding priority: two writes to r7, then drain through output stage
    rf_hold = 1'b1;
    in_valid = 1'b1; in_addr = 5'd7; in_data = 32'hA;
    step();
    in_data = 32'hB;
    step();
    in_valid = 1'b0;
    lk_addr = {5'd8, 5'd7, 5'd0};
    expect_lookup("t5_q", 3'b010, {32'd0, 32'hB, 32'd0});
    rf_hold = 1'b0;
    step();
    expect_lookup("t5_mix", 3'b010, {32'd0, 32'hB, 32'd0});
    step();
    expect_lookup("t5_out", 3'b010, {32'd0, 32'hB, 32'd0});
    step();
    expect_lookup("t5_empty", 3'b000, 96'd0);
    check("t5_rf7", 64'(rf_model[7]), 64'hB);
    lk_addr = 15'd0;

    // 6 Reset mid-drain
    rf_hold = 1'b1;
    for (int i = 10; i <= 12; i++) begin
      in_valid = 1'b1; in_addr = 5'(i); in_data = 32'hC0 + 32'(i);
      step();
    end
    in_valid = 1'b0;
    rf_hold  = 1'b0;
    step();
    check("t6_en_pre", 64'(rf_enable), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    check("t6_en_rst", 64'(rf_enable), 64'd0);
    check("t6_addr_rst", 64'(rf_addr), 64'd0);
    check("t6_ready_rst", 64'(in_ready), 64'd1);
    reset_n = 1'b1;
    wr_log.delete();
    step(); step(); step(); step();
    check("t6_nostale", 64'(wr_log.size()), 64'd0);
    check("t6_ready", 64'(in_ready), 64'd1);
    in_valid = 1'b1; in_addr = 5'd13; in_data = 32'hDD;
    step();
    in_valid = 1'b0;
    step(); step();
    check("t6_post_cnt", 64'(wr_log.size()), 64'd1);
    if (wr_log.size() >= 1)
      check("t6_post", 64'(wr_log[0]), 64'({5'd13, 32'hDD}));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
